ps2_host_tx: RTL



---
 rtl/ps2_pkg.sv | 26 ++
 rtl/ps2_line_sync.sv | 52 +++++
 rtl/ps2_host_tx.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/ps2_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ps2_pkg
// Purpose  : Shared PS/2 constants: FSM encoding, default timings, parity.
// Revision : 1.0 - initial release
// ============================================================================
package ps2_pkg;

    typedef logic [2:0] ps2_state_t;

    localparam ps2_state_t c_ST_IDLE      = 3'd0;
    localparam ps2_state_t c_ST_INHIBIT   = 3'd1;
    localparam ps2_state_t c_ST_RTS       = 3'd2;
    localparam ps2_state_t c_ST_ACK       = 3'd3;
    localparam ps2_state_t c_ST_WAIT_IDLE = 3'd4;

    // Defaults assume clk of about 21.48 MHz.
    localparam int c_INHIBIT_CYCLES = 2600;
    localparam int c_TIMEOUT_CYCLES = 330000;

    function automatic logic odd_parity(input logic [7:0] b);
        return ~^b;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ps2_line_sync.sv
`default_nettype none
// ============================================================================
// Module   : ps2_line_sync
// Purpose  : Multi-stage synchronizer for one PS/2 line plus falling-edge flag.
// Revision : 1.0 - initial release
// ============================================================================
module ps2_line_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic i_line,
    output logic o_level,
    output logic o_fall
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_prev;

    generate
        if (SYNC_STAGES > 1) begin : g_chain
            always_ff @(posedge clk) begin
                if (reset) begin
                    r_sync <= '1;
                end else begin
                    r_sync <= {r_sync[SYNC_STAGES-2:0], i_line};
                end
            end
        end else begin : g_single
            always_ff @(posedge clk) begin
                if (reset) begin
                    r_sync <= '1;
                end else begin
                    r_sync <= i_line;
                end
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            r_prev <= 1'b1;
        end else begin
            r_prev <= r_sync[SYNC_STAGES-1];
        end
    end

    assign o_level = r_sync[SYNC_STAGES-1];
    assign o_fall  = r_prev & ~r_sync[SYNC_STAGES-1];

endmodule
`default_nettype wire

// File: rtl/ps2_host_tx.sv
`default_nettype none
// ============================================================================
// Module   : ps2_host_tx
// Purpose  : Host-to-device PS/2 byte transmitter on open-drain clk/data lines.
//            Optional PS2_HOST_TX_RETRY_EN: up to two automatic re-sends.
// Revision : 1.0 - initial release
// ============================================================================
module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int INHIBIT_CYCLES = c_INHIBIT_CYCLES,
    parameter int TIMEOUT_CYCLES = c_TIMEOUT_CYCLES,
    parameter int SYNC_STAGES    = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    input  logic       ps2_clk_i,
    input  logic       ps2_data_i,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe,
    output logic       busy,
    output logic       done,
    output logic       error
);

    localparam int c_TMAX = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES : TIMEOUT_CYCLES;
    localparam int c_TW   = $clog2(c_TMAX + 1);
    localparam logic [c_TW-1:0] c_INH_LOAD = c_TW'(INHIBIT_CYCLES - 1);
    localparam logic [c_TW-1:0] c_TO_LOAD  = c_TW'(TIMEOUT_CYCLES - 1);

    ps2_state_t      r_state;
    logic [8:0]      r_shift;
    logic [3:0]      r_bitcnt;
    logic [c_TW-1:0] r_timer;
    logic            r_nack;
    logic            r_clk_oe;
    logic            r_data_oe;
    logic            r_done;
    logic            r_error;
`ifdef PS2_HOST_TX_RETRY_EN
    logic [8:0]      r_frame;
    logic [1:0]      r_retry;
`endif

    logic w_clk_level;
    logic w_clk_fall;
    logic w_data_level;
    logic w_data_fall;
    logic w_unused;
    logic w_bus_idle;
    logic w_wait_end;
    logic w_timeout;
    logic w_fail;
    logic w_ok;

    ps2_line_sync #(.SYNC_STAGES(SYNC_STAGES)) u_clk_sync (
        .clk     (clk),
        .reset   (reset),
        .i_line  (ps2_clk_i),
        .o_level (w_clk_level),
        .o_fall  (w_clk_fall)
    );

    ps2_line_sync #(.SYNC_STAGES(SYNC_STAGES)) u_data_sync (
        .clk     (clk),
        .reset   (reset),
        .i_line  (ps2_data_i),
        .o_level (w_data_level),
        .o_fall  (w_data_fall)
    );

    assign w_unused   = w_data_fall;
    assign w_bus_idle = w_clk_level & w_data_level;
    assign w_wait_end = (r_state == c_ST_WAIT_IDLE) & w_bus_idle;

    // A clock fall in the expiry cycle still counts as progress.
    always_comb begin
        w_timeout = 1'b0;
        case (r_state)
            c_ST_RTS, c_ST_ACK: w_timeout = ~w_clk_fall & (r_timer == '0);
            c_ST_WAIT_IDLE:     w_timeout = ~w_bus_idle & (r_timer == '0);
            default:            w_timeout = 1'b0;
        endcase
    end

    assign w_fail = w_timeout | (w_wait_end & r_nack);
    assign w_ok   = w_wait_end & ~r_nack;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= c_ST_IDLE;
            r_shift   <= '0;
            r_bitcnt  <= '0;
            r_timer   <= '0;
            r_nack    <= 1'b0;
            r_clk_oe  <= 1'b0;
            r_data_oe <= 1'b0;
            r_done    <= 1'b0;
            r_error   <= 1'b0;
`ifdef PS2_HOST_TX_RETRY_EN
            r_frame   <= '0;
            r_retry   <= '0;
`endif
        end else begin
            r_done  <= 1'b0;
            r_error <= 1'b0;
            if (w_fail) begin
                r_clk_oe  <= 1'b0;
                r_data_oe <= 1'b0;
                r_nack    <= 1'b0;
                r_bitcnt  <= '0;
`ifdef PS2_HOST_TX_RETRY_EN
                if (r_retry != 2'd2) begin
                    r_retry  <= r_retry + 2'd1;
                    r_shift  <= r_frame;
                    r_clk_oe <= 1'b1;
                    r_timer  <= c_INH_LOAD;
                    r_state  <= c_ST_INHIBIT;
                end else
`endif
                begin
                    r_error <= 1'b1;
                    r_state <= c_ST_IDLE;
                end
            end else if (w_ok) begin
                r_done  <= 1'b1;
                r_state <= c_ST_IDLE;
            end else begin
                case (r_state)
                    c_ST_IDLE: begin
                        if (tx_valid) begin
                            r_shift   <= {odd_parity(tx_data), tx_data};
`ifdef PS2_HOST_TX_RETRY_EN
                            r_frame   <= {odd_parity(tx_data), tx_data};
                            r_retry   <= '0;
`endif
                            r_bitcnt  <= '0;
                            r_nack    <= 1'b0;
                            r_clk_oe  <= 1'b1;
                            r_data_oe <= 1'b0;
                            r_timer   <= c_INH_LOAD;
                            r_state   <= c_ST_INHIBIT;
                        end
                    end
                    c_ST_INHIBIT: begin
                        // Start bit goes low while the clock is still held.
                        if (r_timer == c_TW'(1)) begin
                            r_data_oe <= 1'b1;
                        end
                        if (r_timer == '0) begin
                            r_data_oe <= 1'b1;
                            r_clk_oe  <= 1'b0;
                            r_timer   <= c_TO_LOAD;
                            r_state   <= c_ST_RTS;
                        end else begin
                            r_timer <= r_timer - 1'b1;
                        end
                    end
                    c_ST_RTS: begin
                        if (w_clk_fall) begin
                            r_timer  <= c_TO_LOAD;
                            r_bitcnt <= r_bitcnt + 4'd1;
                            if (r_bitcnt == 4'd9) begin
                                r_data_oe <= 1'b0;
                                r_state   <= c_ST_ACK;
                            end else begin
                                r_data_oe <= ~r_shift[0];
                                r_shift   <= r_shift >> 1;
                            end
                        end else begin
                            r_timer <= r_timer - 1'b1;
                        end
                    end
                    c_ST_ACK: begin
                        if (w_clk_fall) begin
                            r_nack  <= w_data_level;
                            r_timer <= c_TO_LOAD;
                            r_state <= c_ST_WAIT_IDLE;
                        end else begin
                            r_timer <= r_timer - 1'b1;
                        end
                    end
                    c_ST_WAIT_IDLE: begin
                        r_timer <= r_timer - 1'b1;
                    end
                    default: begin
                        r_clk_oe  <= 1'b0;
                        r_data_oe <= 1'b0;
                        r_state   <= c_ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign tx_ready    = (r_state == c_ST_IDLE);
    assign busy        = (r_state != c_ST_IDLE);
    assign ps2_clk_oe  = r_clk_oe;
    assign ps2_data_oe = r_data_oe;
    assign done        = r_done;
    assign error       = r_error;

endmodule
`default_nettype wire
